// File: rtl/h_u_seg_rca.sv
// Segmented ripple-carry adder: one K-bit segment per cycle,
// carry held in a register, valid/ready on both sides.
module h_u_seg_rca #(
  parameter int N = 12,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         is_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   out,
  output logic         busy
);

  localparam int S  = N / K;
  localparam int SW = (S > 1) ? $clog2(S) : 1;

  if (N < 2 || K < 1 || K > N || (N % K) != 0) begin : g_bad_param
    $error("h_u_seg_rca: need N>=2, 1<=K<=N, N%%K==0");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] seg;
  logic          carry;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [N-1:0]  result;
  logic          a_msb;
  logic          b_msb;
  logic          sgn;
  logic [K:0]    seg_sum;
  logic [N+K-1:0] res_cat;
  logic          last;
  logic          msb;
  logic          accept;

  // Operands shift down one segment per cycle; sums enter
  // the result from the top so no variable indexing is needed.
  always_comb begin
    seg_sum = {1'b0, a_sh[K-1:0]}
            + {1'b0, b_sh[K-1:0]}
            + {{K{1'b0}}, carry};
    res_cat = {seg_sum[K-1:0], result};
    last    = (seg == SW'(S - 1));
    msb     = sgn ? (a_msb ^ b_msb ^ seg_sum[K])
                  : seg_sum[K];
    accept  = (state == IDLE) && in_valid && in_ready;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      seg       <= '0;
      carry     <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      result    <= '0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      sgn       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      busy      <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_sh     <= a;
            b_sh     <= b;
            a_msb    <= a[N-1];
            b_msb    <= b[N-1];
            sgn      <= is_signed;
            carry    <= cin;
            seg      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          carry  <= seg_sum[K];
          result <= res_cat[N+K-1:K];
          a_sh   <= a_sh >> K;
          b_sh   <= b_sh >> K;
          seg    <= seg + 1'b1;
          if (last) begin
            out       <= {msb, res_cat[N+K-1:K]};
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_h_u_seg_rca.sv
// Bench for h_u_seg_rca: K=1,3,4,12 instances with N=12,
// directed cases plus random ops against an arithmetic model.
module tb_h_u_seg_rca;

  localparam int N  = 12;
  localparam int NK = 4;
  localparam int W  = N + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         iv   [NK];
  logic         ir   [NK];
  logic         cn   [NK];
  logic         sg   [NK];
  logic         ov   [NK];
  logic         ordy [NK];
  logic         bz   [NK];
  logic [N-1:0] av   [NK];
  logic [N-1:0] bv   [NK];
  logic [N:0]   ot   [NK];

  int n_cmp = 0;
  int n_err = 0;
  int rises [NK];
  int done  [NK];
  logic ov_prev [NK];

  h_u_seg_rca #(.N(N), .K(1)) u_k1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(av[0]), .b(bv[0]), .cin(cn[0]), .is_signed(sg[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out(ot[0]), .busy(bz[0]));
  h_u_seg_rca #(.N(N), .K(3)) u_k3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(av[1]), .b(bv[1]), .cin(cn[1]), .is_signed(sg[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out(ot[1]), .busy(bz[1]));
  h_u_seg_rca #(.N(N), .K(4)) u_k4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(av[2]), .b(bv[2]), .cin(cn[2]), .is_signed(sg[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out(ot[2]), .busy(bz[2]));
  h_u_seg_rca #(.N(N), .K(12)) u_k12 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
    .a(av[3]), .b(bv[3]), .cin(cn[3]), .is_signed(sg[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out(ot[3]), .busy(bz[3]));

  // Count out_valid rising edges per instance.
  always @(negedge clk) begin
    for (int i = 0; i < NK; i++) begin
      if (ov[i] && !ov_prev[i]) rises[i] = rises[i] + 1;
      ov_prev[i] = ov[i];
    end
  end

  function automatic int kval(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      2:       return 4;
      default: return 12;
    endcase
  endfunction

  function automatic logic [N:0] ref_sum(input logic [N-1:0] a,
                                         input logic [N-1:0] b,
                                         input logic c,
                                         input logic s);
    int ea;
    int eb;
    ea = s ? int'($signed(a)) : int'({1'b0, a});
    eb = s ? int'($signed(b)) : int'({1'b0, b});
    return W'(ea + eb + int'(c));
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int i, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic c,
                        input logic s, output bit ok);
    int t;
    t = 0;
    while (!ir[i] && t < 50) begin
      step;
      t++;
    end
    av[i] = a;
    bv[i] = b;
    cn[i] = c;
    sg[i] = s;
    iv[i] = 1'b1;
    ok = ir[i];
    step;
    iv[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i, input bit scramble,
                            output int cyc);
    cyc = 0;
    while (!ov[i] && cyc < 100) begin
      if (scramble) begin
        iv[i] = 1'($urandom);
        av[i] = N'($urandom);
        bv[i] = N'($urandom);
        cn[i] = 1'($urandom);
        sg[i] = 1'($urandom);
      end
      step;
      cyc++;
    end
    iv[i] = 1'b0;
    if (!ov[i]) cyc = -1;
  endtask

  task automatic test_reset;
    #3;
    for (int i = 0; i < NK; i++) begin
      n_cmp++;
      if ({ir[i], ov[i], bz[i], ot[i]} !== '0) begin
        n_err++;
        $display("FAIL reset_state k=%0d: ir=%b ov=%b bz=%b out=%h, want all 0",
                 kval(i), ir[i], ov[i], bz[i], ot[i]);
      end
    end
    step;
    step;
    rst_n = 1'b1;
    for (int i = 0; i < NK; i++) begin
      n_cmp++;
      if (ir[i] !== 1'b0) begin
        n_err++;
        $display("FAIL ready_before_edge k=%0d: ir=%b want 0", kval(i), ir[i]);
      end
    end
    step;
    for (int i = 0; i < NK; i++) begin
      n_cmp++;
      if (ir[i] !== 1'b1) begin
        n_err++;
        $display("FAIL ready_after_reset k=%0d: ir=%b want 1", kval(i), ir[i]);
      end
    end
  endtask

  task automatic test_directed;
    logic [N-1:0] ta [4];
    logic [N-1:0] tb [4];
    logic         tc [4];
    logic         ts [4];
    logic [N:0]   te [4];
    bit ok;
    int cyc;
    ta = '{12'hFFF, 12'h800, 12'h800, 12'h0FF};
    tb = '{12'h001, 12'h000, 12'h000, 12'h000};
    tc = '{1'b0, 1'b0, 1'b0, 1'b1};
    ts = '{1'b0, 1'b1, 1'b0, 1'b0};
    te = '{13'h1000, 13'h1800, 13'h0800, 13'h0100};
    for (int j = 0; j < 4; j++) begin
      accept(2, ta[j], tb[j], tc[j], ts[j], ok);
      n_cmp++;
      if (!ok || ir[2] !== 1'b0 || bz[2] !== 1'b1) begin
        n_err++;
        $display("FAIL dir_accept %0d: ok=%0d ir=%b bz=%b want 1/0/1",
                 j, ok, ir[2], bz[2]);
      end
      wait_valid(2, 1'b0, cyc);
      n_cmp++;
      if (cyc != 3) begin
        n_err++;
        $display("FAIL dir_latency %0d: got %0d cycles want 3", j, cyc);
      end
      n_cmp++;
      if (ot[2] !== te[j]) begin
        n_err++;
        $display("FAIL dir_sum %0d: got %h want %h", j, ot[2], te[j]);
      end
      ordy[2] = 1'b1;
      step;
      ordy[2] = 1'b0;
      done[2]++;
      n_cmp++;
      if (ov[2] !== 1'b0 || ir[2] !== 1'b1 || bz[2] !== 1'b0) begin
        n_err++;
        $display("FAIL dir_release %0d: ov=%b ir=%b bz=%b want 0/1/0",
                 j, ov[2], ir[2], bz[2]);
      end
    end
  endtask

  task automatic test_stall;
    bit ok;
    int cyc;
    logic [N:0] exp;
    exp = 13'h056A;
    accept(2, 12'h3A5, 12'h1C4, 1'b1, 1'b0, ok);
    wait_valid(2, 1'b0, cyc);
    for (int t = 0; t < 5; t++) begin
      iv[2] = t[0];
      av[2] = N'($urandom);
      bv[2] = N'($urandom);
      step;
      n_cmp++;
      if (ov[2] !== 1'b1 || ot[2] !== exp || ir[2] !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold %0d: ov=%b out=%h ir=%b want 1/%h/0",
                 t, ov[2], ot[2], ir[2], exp);
      end
    end
    iv[2] = 1'b0;
    ordy[2] = 1'b1;
    step;
    ordy[2] = 1'b0;
    done[2]++;
    n_cmp++;
    if (ov[2] !== 1'b0 || ir[2] !== 1'b1 || ot[2] !== exp) begin
      n_err++;
      $display("FAIL stall_release: ov=%b ir=%b out=%h want 0/1/%h",
               ov[2], ir[2], ot[2], exp);
    end
  endtask

  task automatic test_abort;
    bit ok;
    int cyc;
    accept(2, 12'hABC, 12'h321, 1'b1, 1'b1, ok);
    step;
    step;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ir[2], ov[2], bz[2], ot[2]} !== '0) begin
      n_err++;
      $display("FAIL abort_clear: ir=%b ov=%b bz=%b out=%h want all 0",
               ir[2], ov[2], bz[2], ot[2]);
    end
    step;
    rst_n = 1'b1;
    step;
    step;
    n_cmp++;
    if (ov[2] !== 1'b0 || ir[2] !== 1'b1) begin
      n_err++;
      $display("FAIL abort_idle: ov=%b ir=%b want 0/1", ov[2], ir[2]);
    end
    accept(2, 12'h123, 12'h456, 1'b0, 1'b0, ok);
    wait_valid(2, 1'b0, cyc);
    n_cmp++;
    if (cyc != 3 || ot[2] !== 13'h0579) begin
      n_err++;
      $display("FAIL abort_next: cyc=%0d out=%h want 3/0579", cyc, ot[2]);
    end
    ordy[2] = 1'b1;
    step;
    ordy[2] = 1'b0;
    done[2]++;
  endtask

  task automatic test_random;
    bit ok;
    int cyc;
    int stall;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic rc;
    logic rs;
    logic [N:0] exp;
    for (int i = 0; i < NK; i++) begin
      for (int k = 0; k < 250; k++) begin
        ra = N'($urandom);
        rb = N'($urandom);
        rc = 1'($urandom);
        rs = 1'($urandom);
        exp = ref_sum(ra, rb, rc, rs);
        accept(i, ra, rb, rc, rs, ok);
        n_cmp++;
        if (!ok) begin
          n_err++;
          $display("FAIL rnd_accept k=%0d op=%0d: in_ready never rose",
                   kval(i), k);
        end
        wait_valid(i, 1'b1, cyc);
        n_cmp++;
        if (cyc != N / kval(i)) begin
          n_err++;
          $display("FAIL rnd_latency k=%0d op=%0d: got %0d want %0d",
                   kval(i), k, cyc, N / kval(i));
        end
        stall = $urandom_range(0, 3);
        for (int t = 0; t < stall; t++) step;
        n_cmp++;
        if (ov[i] !== 1'b1 || ot[i] !== exp) begin
          n_err++;
          $display("FAIL rnd_sum k=%0d a=%h b=%h c=%b s=%b: ov=%b out=%h want %h",
                   kval(i), ra, rb, rc, rs, ov[i], ot[i], exp);
        end
        ordy[i] = 1'b1;
        step;
        ordy[i] = 1'b0;
        done[i]++;
        n_cmp++;
        if (ov[i] !== 1'b0) begin
          n_err++;
          $display("FAIL rnd_release k=%0d op=%0d: ov=%b want 0",
                   kval(i), k, ov[i]);
        end
      end
    end
    step;
    for (int i = 0; i < NK; i++) begin
      n_cmp++;
      if (rises[i] != done[i]) begin
        n_err++;
        $display("FAIL op_count k=%0d: results=%0d want %0d",
                 kval(i), rises[i], done[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NK; i++) begin
      iv[i] = 1'b0;
      cn[i] = 1'b0;
      sg[i] = 1'b0;
      ordy[i] = 1'b0;
      av[i] = '0;
      bv[i] = '0;
      rises[i] = 0;
      done[i] = 0;
      ov_prev[i] = 1'b0;
    end
    test_reset;
    test_directed;
    test_stall;
    test_abort;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
